// File: rtl/exe_pkg.sv
// Shared definitions for the execute stage: ALU command codes, shift types,
// flag bit positions and the multiplier FSM states.
package exe_pkg;

  localparam int unsigned MUL_CYCLES = 32;
  localparam logic [4:0]  MUL_LAST   = 5'(MUL_CYCLES - 1);

  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_MVN = 4'b1001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;
  localparam logic [3:0] CMD_MUL = 4'b1010;

  localparam logic [1:0] SH_LSL = 2'd0;
  localparam logic [1:0] SH_LSR = 2'd1;
  localparam logic [1:0] SH_ASR = 2'd2;
  localparam logic [1:0] SH_ROR = 2'd3;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_e;

  // Rotate right; a zero amount leaves the word untouched because the
  // complementary left shift by 32 yields zero.
  function automatic logic [31:0] ror32(input logic [31:0] x, input logic [4:0] n);
    return (x >> n) | (x << (6'd32 - {1'b0, n}));
  endfunction

endpackage

// File: rtl/exe_stage_seq_multiplier.sv
// Iterative shift-add multiplier, 32x32 -> low 32 bits, one bit per cycle.
module seq_multiplier
  import exe_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] product
);

  mul_state_e  state, state_next;
  logic [4:0]  cnt;
  logic [31:0] acc, mcand, mplier;

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Next state; busy covers the accepting cycle so the pipeline freezes at once
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: if (start) begin
        busy       = 1'b1;
        state_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (cnt == MUL_LAST) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand latch and one shift-add step per RUN cycle
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          cnt    <= '0;
          acc    <= '0;
          mcand  <= a;
          mplier <= b;
        end
        RUN: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 5'd1;
        end
        default: ;
      endcase
    end
  end

  assign product = acc;

endmodule

// File: rtl/exe_stage.sv
// Execute stage: Val2 generation, ALU, branch target and the EXE/MEM register.
module exe_stage
  import exe_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_en_in,
  input  logic        mem_r_en_in,
  input  logic        mem_w_en_in,
  input  logic        imm_in,
  input  logic [3:0]  exe_cmd_in,
  input  logic        b_in,
  input  logic        s_in,
  input  logic [31:0] pc_in,
  input  logic [31:0] val_rn_in,
  input  logic [31:0] val_rm_in,
  input  logic [7:0]  immed_8_in,
  input  logic [3:0]  rotate_imm_in,
  input  logic [23:0] signed_imm_24_in,
  input  logic [3:0]  dest_in,
  input  logic [3:0]  status_in,
  output logic        stall,
  output logic        branch_taken,
  output logic [31:0] branch_addr,
  output logic        mem_wb_en,
  output logic        mem_r_en,
  output logic        mem_w_en,
  output logic [31:0] alu_res,
  output logic [31:0] st_val,
  output logic [3:0]  mem_dest,
  output logic        status_we,
  output logic [3:0]  status_nzcv
);

  logic        mul_busy, mul_done;
  logic [31:0] mul_product;
  logic [31:0] val2, res;
  logic [32:0] sum;
  logic [3:0]  nzcv_next;
  logic [11:0] so;
  logic        c_out, v_out, flags_upd;

  seq_multiplier u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (exe_cmd_in == CMD_MUL),
    .a       (val_rn_in),
    .b       (val_rm_in),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  assign stall        = mul_busy;
  assign branch_taken = b_in & ~stall;
  assign branch_addr  = pc_in + {{6{signed_imm_24_in[23]}}, signed_imm_24_in, 2'b00};
  assign so           = {rotate_imm_in, immed_8_in};

  // Operand 2: rotated immediate, load/store offset, or shifted Rm
  always_comb begin
    val2 = '0;
    if (imm_in) begin
      val2 = ror32({24'b0, immed_8_in}, {rotate_imm_in, 1'b0});
    end else if (mem_r_en_in || mem_w_en_in) begin
      val2 = {20'b0, so};
    end else begin
      case (so[6:5])
        SH_LSL:  val2 = val_rm_in << so[11:7];
        SH_LSR:  val2 = val_rm_in >> so[11:7];
        SH_ASR:  val2 = $signed(val_rm_in) >>> so[11:7];
        default: val2 = ror32(val_rm_in, so[11:7]);
      endcase
    end
  end

  // ALU result and new NZCV; unknown commands leave the flags as they were
  always_comb begin
    sum       = '0;
    res       = '0;
    c_out     = status_in[FLAG_C];
    v_out     = status_in[FLAG_V];
    flags_upd = 1'b1;
    case (exe_cmd_in)
      CMD_MOV: res = val2;
      CMD_MVN: res = ~val2;
      CMD_AND: res = val_rn_in & val2;
      CMD_ORR: res = val_rn_in | val2;
      CMD_EOR: res = val_rn_in ^ val2;
      CMD_MUL: res = mul_product;
      CMD_ADD, CMD_ADC: begin
        sum   = {1'b0, val_rn_in} + {1'b0, val2}
              + {32'b0, (exe_cmd_in == CMD_ADC) & status_in[FLAG_C]};
        res   = sum[31:0];
        c_out = sum[32];
        v_out = (val_rn_in[31] == val2[31]) && (res[31] != val_rn_in[31]);
      end
      CMD_SUB, CMD_SBC: begin
        // a - b - borrow computed as a + ~b + carry-in, so C is "no borrow"
        sum   = {1'b0, val_rn_in} + {1'b0, ~val2}
              + {32'b0, (exe_cmd_in == CMD_SUB) | status_in[FLAG_C]};
        res   = sum[31:0];
        c_out = sum[32];
        v_out = (val_rn_in[31] != val2[31]) && (res[31] != val_rn_in[31]);
      end
      default: flags_upd = 1'b0;
    endcase
    nzcv_next = status_in;
    if (flags_upd) begin
      nzcv_next[FLAG_N] = res[31];
      nzcv_next[FLAG_Z] = (res == '0);
      nzcv_next[FLAG_C] = c_out;
      nzcv_next[FLAG_V] = v_out;
    end
  end

  // EXE/MEM register; a bubble is loaded while the multiplier holds the pipe
  always_ff @(posedge clk) begin
    if (!rst || stall) begin
      mem_wb_en   <= 1'b0;
      mem_r_en    <= 1'b0;
      mem_w_en    <= 1'b0;
      alu_res     <= '0;
      st_val      <= '0;
      mem_dest    <= '0;
      status_we   <= 1'b0;
      status_nzcv <= '0;
    end else begin
      mem_wb_en   <= wb_en_in;
      mem_r_en    <= mem_r_en_in;
      mem_w_en    <= mem_w_en_in;
      alu_res     <= res;
      st_val      <= val_rm_in;
      mem_dest    <= dest_in;
      status_we   <= s_in;
      status_nzcv <= nzcv_next;
    end
  end

endmodule

// File: tb/tb_exe_stage.sv
// Self-checking bench for exe_stage against a behavioural arithmetic model.
module tb_exe_stage;

  localparam logic [3:0] C_MOV = 4'b0001, C_ADD = 4'b0010, C_SUB = 4'b0100, C_MUL = 4'b1010;

  typedef struct packed {
    logic        wb, r, w, imm, b, s;
    logic [3:0]  cmd;
    logic [31:0] pc, rn, rm;
    logic [7:0]  i8;
    logic [3:0]  rot;
    logic [23:0] i24;
    logic [3:0]  dest, st;
  } stim_t;

  logic        clk = 1'b0, rst = 1'b0;
  logic        wb_en_in, mem_r_en_in, mem_w_en_in, imm_in, b_in, s_in;
  logic [3:0]  exe_cmd_in, rotate_imm_in, dest_in, status_in;
  logic [31:0] pc_in, val_rn_in, val_rm_in;
  logic [7:0]  immed_8_in;
  logic [23:0] signed_imm_24_in;
  logic        stall, branch_taken, mem_wb_en, mem_r_en, mem_w_en, status_we;
  logic [31:0] branch_addr, alu_res, st_val;
  logic [3:0]  mem_dest, status_nzcv;
  logic [75:0] obs;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  exe_stage dut (
    .clk(clk), .rst(rst), .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in),
    .mem_w_en_in(mem_w_en_in), .imm_in(imm_in), .exe_cmd_in(exe_cmd_in), .b_in(b_in),
    .s_in(s_in), .pc_in(pc_in), .val_rn_in(val_rn_in), .val_rm_in(val_rm_in),
    .immed_8_in(immed_8_in), .rotate_imm_in(rotate_imm_in),
    .signed_imm_24_in(signed_imm_24_in), .dest_in(dest_in), .status_in(status_in),
    .stall(stall), .branch_taken(branch_taken), .branch_addr(branch_addr),
    .mem_wb_en(mem_wb_en), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .alu_res(alu_res),
    .st_val(st_val), .mem_dest(mem_dest), .status_we(status_we), .status_nzcv(status_nzcv)
  );

  assign obs = {mem_wb_en, mem_r_en, mem_w_en, alu_res, st_val, mem_dest, status_we, status_nzcv};

  task automatic apply(input stim_t t);
    wb_en_in = t.wb; mem_r_en_in = t.r; mem_w_en_in = t.w; imm_in = t.imm;
    exe_cmd_in = t.cmd; b_in = t.b; s_in = t.s; pc_in = t.pc;
    val_rn_in = t.rn; val_rm_in = t.rm; immed_8_in = t.i8; rotate_imm_in = t.rot;
    signed_imm_24_in = t.i24; dest_in = t.dest; status_in = t.st;
  endtask

  // Operand 2 from its definition: rotations/shifts applied one bit at a time.
  function automatic logic [31:0] m_val2(input stim_t t);
    logic [11:0] so;
    logic [31:0] v;
    int unsigned n;
    so = {t.rot, t.i8};
    if (t.imm) begin
      v = {24'b0, t.i8};
      for (int unsigned k = 0; k < 2 * t.rot; k++) v = {v[0], v[31:1]};
      return v;
    end
    if (t.r || t.w) return {20'b0, so};
    v = t.rm;
    n = so[11:7];
    for (int unsigned k = 0; k < n; k++)
      case (so[6:5])
        2'd0: v = v * 2;
        2'd1: v = v / 2;
        2'd2: v = (v / 2) | (v & 32'h8000_0000);
        default: v = {v[0], v[31:1]};
      endcase
    return v;
  endfunction

  // {NZCV, result} using wide integer arithmetic for carry and overflow.
  function automatic logic [35:0] m_alu(input logic [3:0] cmd, input logic [31:0] a, b,
                                        input logic [3:0] st, input logic [31:0] prod);
    longint ua, ub, sa, sb, u, s, ci;
    logic [31:0] r;
    logic c, v, arith;
    ua = longint'(a); ub = longint'(b);
    sa = longint'($signed(a)); sb = longint'($signed(b));
    ci = st[1] ? 64'sd1 : 64'sd0;
    u = 0; s = 0; r = '0; c = st[1]; v = st[0]; arith = 1'b0;
    case (cmd)
      4'd1:  r = b;
      4'd9:  r = ~b;
      4'd6:  r = a & b;
      4'd7:  r = a | b;
      4'd8:  r = a ^ b;
      4'd10: r = prod;
      4'd2: begin u = ua + ub;      s = sa + sb;      arith = 1'b1; c = (u > 64'sh0FFFFFFFF); end
      4'd3: begin u = ua + ub + ci; s = sa + sb + ci; arith = 1'b1; c = (u > 64'sh0FFFFFFFF); end
      4'd4: begin u = ua - ub;            s = sa - sb;            arith = 1'b1; c = (u >= 0); end
      4'd5: begin u = ua - ub - (1 - ci); s = sa - sb - (1 - ci); arith = 1'b1; c = (u >= 0); end
      default: return {st, 32'h0};
    endcase
    if (arith) begin
      r = u[31:0];
      v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    end
    return {r[31], r == 32'h0, c, v, r};
  endfunction

  function automatic logic [75:0] m_commit(input stim_t t);
    logic [31:0] prod, res;
    logic [3:0]  f;
    prod = t.rn * t.rm;
    {f, res} = m_alu(t.cmd, t.rn, m_val2(t), t.st, prod);
    return {t.wb, t.r, t.w, res, t.rm, t.dest, t.s, f};
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  function automatic stim_t rand_stim();
    stim_t t;
    t = '0;
    t.cmd = 4'($urandom_range(0, 15));
    if (t.cmd == C_MUL) t.cmd = C_SUB;
    t.imm = ($urandom_range(0, 2) == 0);
    case ($urandom_range(0, 5))
      0: t.r = 1'b1;
      1: t.w = 1'b1;
      default: ;
    endcase
    t.wb = 1'($urandom); t.s = 1'($urandom); t.b = 1'($urandom);
    t.pc = $urandom; t.rn = pick(); t.rm = pick();
    t.i8 = 8'($urandom); t.rot = 4'($urandom); t.i24 = 24'($urandom);
    t.dest = 4'($urandom); t.st = 4'($urandom);
    return t;
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    apply('0);
    @(posedge clk); #1;
    vectors++;
    if ({stall, obs} !== 77'h0) begin
      miscompares++;
      $display("FAIL reset got stall=%b regs=%h want 0", stall, obs);
    end
    rst = 1'b1;
  endtask

  task automatic test_add();
    stim_t t = '0;
    t.wb = 1; t.s = 1; t.cmd = C_ADD; t.rn = 5; t.rm = 7;
    apply(t); #1;
    vectors++;
    if (stall !== 1'b0) begin miscompares++; $display("FAIL add_stall got=%b want=0", stall); end
    @(posedge clk); #1;
    vectors++;
    if ({alu_res, status_nzcv, status_we, mem_wb_en} !== {32'd12, 4'b0000, 1'b1, 1'b1}) begin
      miscompares++;
      $display("FAIL add got res=%h nzcv=%b we=%b wb=%b want 0000000c/0000/1/1",
               alu_res, status_nzcv, status_we, mem_wb_en);
    end
  endtask

  task automatic test_sub();
    stim_t t = '0;
    t.wb = 1; t.s = 1; t.cmd = C_SUB; t.rn = 3; t.rm = 5;
    apply(t); @(posedge clk); #1;
    vectors++;
    if ({alu_res, status_nzcv} !== {32'hFFFF_FFFE, 4'b1000}) begin
      miscompares++;
      $display("FAIL sub_neg got res=%h nzcv=%b want fffffffe/1000", alu_res, status_nzcv);
    end
    t.rn = 5;
    apply(t); @(posedge clk); #1;
    vectors++;
    if ({alu_res, status_nzcv} !== {32'h0, 4'b0110}) begin
      miscompares++;
      $display("FAIL sub_zero got res=%h nzcv=%b want 00000000/0110", alu_res, status_nzcv);
    end
  endtask

  task automatic test_mov();
    stim_t t = '0;
    t.wb = 1; t.cmd = C_MOV; t.imm = 1; t.i8 = 8'hFF; t.rot = 4'd4;
    apply(t); @(posedge clk); #1;
    vectors++;
    if (alu_res !== 32'hFF00_0000) begin
      miscompares++; $display("FAIL mov_imm got=%h want=ff000000", alu_res);
    end
    t.imm = 0; t.rot = 4'd1; t.i8 = 8'h00; t.rm = 32'd1;
    apply(t); @(posedge clk); #1;
    vectors++;
    if (alu_res !== 32'd4) begin
      miscompares++; $display("FAIL mov_lsl got=%h want=00000004", alu_res);
    end
  endtask

  task automatic test_branch();
    stim_t t = '0;
    t.b = 1; t.pc = 32'h100; t.i24 = 24'hFFFFFE;
    apply(t); #1;
    vectors++;
    if ({branch_taken, branch_addr} !== {1'b1, 32'h0000_00F8}) begin
      miscompares++;
      $display("FAIL branch_back got taken=%b addr=%h want 1/000000f8", branch_taken, branch_addr);
    end
    t.i24 = 24'h000010;
    apply(t); #1;
    vectors++;
    if ({branch_taken, branch_addr} !== {1'b1, 32'h0000_0140}) begin
      miscompares++;
      $display("FAIL branch_fwd got taken=%b addr=%h want 1/00000140", branch_taken, branch_addr);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_mul(input logic [31:0] a, input logic [31:0] b, input logic [3:0] st);
    stim_t t = '0;
    int n, bad;
    t.wb = 1; t.s = 1; t.cmd = C_MUL; t.rn = a; t.rm = b; t.dest = 4'hA; t.st = st;
    t.b = 1; t.pc = 32'h100; t.i24 = 24'hFFFFFE;
    apply(t); #1;
    vectors++;
    if ({stall, branch_taken} !== 2'b10) begin
      miscompares++;
      $display("FAIL mul_issue got stall=%b taken=%b want 1/0", stall, branch_taken);
    end
    t.b = 0;
    apply(t);
    n = 1; bad = 0;
    for (int i = 0; i < 64; i++) begin
      @(posedge clk); #1;
      if (obs !== 76'h0) bad++;
      if (!stall) break;
      n++;
    end
    vectors++;
    if (n != 33 || bad != 0) begin
      miscompares++;
      $display("FAIL mul_stall got cycles=%0d nonbubbles=%0d want 33/0", n, bad);
    end
    @(posedge clk); #1;
    vectors++;
    if (obs !== m_commit(t)) begin
      miscompares++;
      $display("FAIL mul_result a=%h b=%h got=%h want=%h", a, b, obs, m_commit(t));
    end
    apply('0); #1;
    vectors++;
    if (stall !== 1'b0) begin miscompares++; $display("FAIL mul_after got stall=%b want=0", stall); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_mul();
    stim_t t = '0;
    stim_t u;
    t.wb = 1; t.cmd = C_MUL; t.rn = 6; t.rm = 7;
    apply(t);
    repeat (11) @(posedge clk);
    #1;
    vectors++;
    if (stall !== 1'b1) begin miscompares++; $display("FAIL midmul_running got stall=%b want=1", stall); end
    rst = 1'b0;
    apply('0);
    @(posedge clk); #1;
    rst = 1'b1;
    vectors++;
    if ({stall, obs} !== 77'h0) begin
      miscompares++;
      $display("FAIL midmul_reset got stall=%b regs=%h want 0", stall, obs);
    end
    u = rand_stim();
    u.cmd = C_ADD;
    apply(u); @(posedge clk); #1;
    vectors++;
    if (obs !== m_commit(u)) begin
      miscompares++;
      $display("FAIL midmul_next got=%h want=%h", obs, m_commit(u));
    end
  endtask

  task automatic test_back_to_back();
    stim_t t;
    logic [31:0] ba;
    for (int i = 0; i < 300; i++) begin
      if (i % 40 == 39) test_mul(pick(), pick(), 4'($urandom));
      t = rand_stim();
      ba = t.pc + 32'(longint'($signed(t.i24)) * 4);
      apply(t); #1;
      vectors++;
      if ({stall, branch_taken, branch_addr} !== {1'b0, t.b, ba}) begin
        miscompares++;
        $display("FAIL b2b_comb[%0d] got stall=%b taken=%b addr=%h want 0/%b/%h",
                 i, stall, branch_taken, branch_addr, t.b, ba);
      end
      @(posedge clk); #1;
      vectors++;
      if (obs !== m_commit(t)) begin
        miscompares++;
        $display("FAIL b2b[%0d] cmd=%h got=%h want=%h", i, t.cmd, obs, m_commit(t));
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_mov();
    test_branch();
    test_mul(32'd6, 32'd7, 4'b0000);
    test_reset_mid_mul();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
